hamming_decode: RTL and testbench

Single-error-correcting decoder for the 21-bit Hamming codewords produced on the write side of the ECC path. It recovers 16-bit data, corrects any single-bit error, and flags syndromes that point outside the codeword as uncorrectable. It sits at the receive end of the link or memory and keeps saturating error-event counters for status readout.

---
 rtl/hamming_decode.sv | 142 ++++++++++++++
 tb/tb_hamming_decode.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decode.sv
// hamming_decode: two-stage single-error-correcting decoder for 21-bit
// Hamming codewords carrying 16 data bits. Stage 1 registers the codeword
// together with its syndrome. Stage 2 applies the correction, extracts the
// data and raises the error flags. Two saturating counters record how many
// words were corrected and how many were uncorrectable.
// All flops update on the falling edge of clk.
module hamming_decode #(
   parameter int data_width     = 16,
   parameter int encoding_width = 21,
   parameter int count_width    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [encoding_width-1:0] encoded_data,
   input  logic                      valid_in,
   input  logic                      cnt_clr,
   output logic [data_width-1:0]     raw_data,
   output logic                      valid_out,
   output logic                      err_corrected,
   output logic                      err_uncorrectable,
   output logic [4:0]                syndrome_out,
   output logic [count_width-1:0]    corr_count,
   output logic [count_width-1:0]    uncorr_count
);

   // Each mask selects the codeword bits whose 1-indexed position has
   // syndrome bit k set (bit b holds position b+1).
   localparam logic [20:0] SYN_MASK0 = 21'h155555;
   localparam logic [20:0] SYN_MASK1 = 21'h066666;
   localparam logic [20:0] SYN_MASK2 = 21'h187878;
   localparam logic [20:0] SYN_MASK3 = 21'h007F80;
   localparam logic [20:0] SYN_MASK4 = 21'h1F8000;

   localparam logic [4:0] LAST_POS = 5'd21;

   // Stage 1 state
   logic [20:0]            cw_q, cw_d;
   logic [4:0]             syn_q, syn_d;
   logic                   v1_q, v1_d;

   // Stage 2 state
   logic [15:0]            raw_q, raw_d;
   logic [4:0]             syn_out_q, syn_out_d;
   logic                   vo_q, vo_d;
   logic                   ec_q, ec_d;
   logic                   eu_q, eu_d;
   logic [count_width-1:0] cc_q, cc_d;
   logic [count_width-1:0] uc_q, uc_d;

   // Correction datapath between the stages
   logic [20:0]            cw_fix;
   logic                   syn_in_range;
   logic                   syn_nonzero;

   // Syndrome from the incoming codeword; stage valid follows valid_in.
   always_comb begin
      syn_d[0] = ^(encoded_data & SYN_MASK0);
      syn_d[1] = ^(encoded_data & SYN_MASK1);
      syn_d[2] = ^(encoded_data & SYN_MASK2);
      syn_d[3] = ^(encoded_data & SYN_MASK3);
      syn_d[4] = ^(encoded_data & SYN_MASK4);
      cw_d     = encoded_data;
      v1_d     = valid_in;
   end

   // Flip the addressed bit for an in-range syndrome; otherwise pass through.
   always_comb begin
      syn_nonzero  = (syn_q != 5'd0);
      syn_in_range = syn_nonzero && (syn_q <= LAST_POS);
      cw_fix       = cw_q;
      if (syn_in_range) begin
         cw_fix = cw_q ^ (21'd1 << (syn_q - 5'd1));
      end
   end

   // Stage 2 outputs and saturating counters; data and syndrome hold when idle.
   always_comb begin
      raw_d     = raw_q;
      syn_out_d = syn_out_q;
      vo_d      = 1'b0;
      ec_d      = 1'b0;
      eu_d      = 1'b0;
      cc_d      = cc_q;
      uc_d      = uc_q;

      if (v1_q) begin
         raw_d     = {cw_fix[20:16], cw_fix[14:8], cw_fix[6:4], cw_fix[2]};
         syn_out_d = syn_q;
         vo_d      = 1'b1;
         ec_d      = syn_in_range;
         eu_d      = syn_nonzero && !syn_in_range;
      end

      if (cnt_clr) begin
         cc_d = '0;
         uc_d = '0;
      end else begin
         if (ec_d && (cc_q != '1)) begin
            cc_d = cc_q + count_width'(1);
         end
         if (eu_d && (uc_q != '1)) begin
            uc_d = uc_q + count_width'(1);
         end
      end
   end

   // Pipeline registers, falling-edge clocked, asynchronous reset.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         cw_q      <= '0;
         syn_q     <= '0;
         v1_q      <= 1'b0;
         raw_q     <= '0;
         syn_out_q <= '0;
         vo_q      <= 1'b0;
         ec_q      <= 1'b0;
         eu_q      <= 1'b0;
         cc_q      <= '0;
         uc_q      <= '0;
      end else begin
         cw_q      <= cw_d;
         syn_q     <= syn_d;
         v1_q      <= v1_d;
         raw_q     <= raw_d;
         syn_out_q <= syn_out_d;
         vo_q      <= vo_d;
         ec_q      <= ec_d;
         eu_q      <= eu_d;
         cc_q      <= cc_d;
         uc_q      <= uc_d;
      end
   end

   assign raw_data          = raw_q;
   assign valid_out         = vo_q;
   assign err_corrected     = ec_q;
   assign err_uncorrectable = eu_q;
   assign syndrome_out      = syn_out_q;
   assign corr_count        = cc_q;
   assign uncorr_count      = uc_q;

endmodule

// File: tb/tb_hamming_decode.sv
// tb_hamming_decode: table-driven vectors, hand-written counter and reset
// sequences, and randomized traffic checked against a position-arithmetic
// reference model of the decoder.
module tb_hamming_decode;

   logic        clk;
   logic        rst;
   logic [20:0] encoded_data;
   logic        valid_in;
   logic        cnt_clr;
   logic [15:0] raw_data;
   logic        valid_out;
   logic        err_corrected;
   logic        err_uncorrectable;
   logic [4:0]  syndrome_out;
   logic [15:0] corr_count;
   logic [15:0] uncorr_count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic        m_v1;
   logic [20:0] m_cw;
   logic [15:0] m_raw;
   logic [4:0]  m_syn;
   logic        m_vo, m_ec, m_eu;
   int          m_cc, m_uc;

   typedef struct {
      logic [20:0] cw;
      logic [15:0] data;
      logic [4:0]  syn;
      logic        ec;
      logic        eu;
   } vec_t;

   vec_t vecs[6];

   hamming_decode #(.data_width(16), .encoding_width(21), .count_width(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .encoded_data      (encoded_data),
      .valid_in          (valid_in),
      .cnt_clr           (cnt_clr),
      .raw_data          (raw_data),
      .valid_out         (valid_out),
      .err_corrected     (err_corrected),
      .err_uncorrectable (err_uncorrectable),
      .syndrome_out      (syndrome_out),
      .corr_count        (corr_count),
      .uncorr_count      (uncorr_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Syndrome = XOR of the 1-indexed positions of all set bits.
   function automatic logic [4:0] ref_syn(input logic [20:0] cw);
      int s = 0;
      for (int p = 1; p <= 21; p++) if (cw[p-1]) s = s ^ p;
      return s[4:0];
   endfunction

   // Data bits occupy the non-power-of-two positions in ascending order.
   function automatic logic [15:0] ref_extract(input logic [20:0] cw);
      logic [15:0] d = '0;
      int j = 0;
      for (int p = 1; p <= 21; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = cw[p-1];
            j++;
         end
      end
      return d;
   endfunction

   function automatic logic [20:0] ref_encode(input logic [15:0] d);
      logic [20:0] cw = '0;
      logic [4:0]  s;
      int j = 0;
      for (int p = 1; p <= 21; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[j];
            j++;
         end
      end
      s = ref_syn(cw);
      for (int k = 0; k < 5; k++) if (s[k]) cw[(1 << k) - 1] = 1'b1;
      return cw;
   endfunction

   task automatic model_reset();
      m_v1 = 1'b0; m_cw = '0; m_raw = '0; m_syn = '0;
      m_vo = 1'b0; m_ec = 1'b0; m_eu = 1'b0; m_cc = 0; m_uc = 0;
   endtask

   task automatic model_edge(input logic [20:0] cw, input logic v, input logic clr);
      int s;
      logic [20:0] fix;
      if (m_v1) begin
         s   = int'(ref_syn(m_cw));
         fix = m_cw;
         if (s >= 1 && s <= 21) fix[s-1] = ~fix[s-1];
         m_raw = ref_extract(fix);
         m_syn = s[4:0];
         m_vo  = 1'b1;
         m_ec  = (s >= 1 && s <= 21);
         m_eu  = (s >= 22);
      end else begin
         m_vo = 1'b0; m_ec = 1'b0; m_eu = 1'b0;
      end
      if (clr) begin
         m_cc = 0; m_uc = 0;
      end else begin
         if (m_ec && m_cc < 65535) m_cc++;
         if (m_eu && m_uc < 65535) m_uc++;
      end
      m_v1 = v;
      m_cw = cw;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("valid_out", 32'(valid_out), 32'(m_vo));
      chk("err_corrected", 32'(err_corrected), 32'(m_ec));
      chk("err_uncorrectable", 32'(err_uncorrectable), 32'(m_eu));
      chk("raw_data", 32'(raw_data), 32'(m_raw));
      chk("syndrome_out", 32'(syndrome_out), 32'(m_syn));
      chk("corr_count", 32'(corr_count), m_cc);
      chk("uncorr_count", 32'(uncorr_count), m_uc);
   endtask

   // Drive one cycle, let the falling edge happen, then optionally compare.
   task automatic cycle(input logic [20:0] cw, input logic v, input logic clr, input bit do_chk);
      encoded_data = cw;
      valid_in     = v;
      cnt_clr      = clr;
      @(negedge clk);
      model_edge(cw, v, clr);
      #1;
      if (do_chk) chk_model();
   endtask

   initial begin
      logic [20:0] w;
      logic [15:0] d;

      vecs[0] = '{21'h000000, 16'h0000, 5'd0,  1'b0, 1'b0};
      vecs[1] = '{21'h1FFFFE, 16'hFFFF, 5'd0,  1'b0, 1'b0};
      vecs[2] = '{21'h000004, 16'h0000, 5'd3,  1'b1, 1'b0};
      vecs[3] = '{21'h1FFFFF, 16'hFFFF, 5'd1,  1'b1, 1'b0};
      vecs[4] = '{21'h100002, 16'h8000, 5'd23, 1'b0, 1'b1};
      vecs[5] = '{21'h000003, 16'h0001, 5'd3,  1'b1, 1'b0};

      rst = 1'b1; encoded_data = '0; valid_in = 1'b0; cnt_clr = 1'b0;
      model_reset();
      #1;
      chk_model();
      @(posedge clk);
      rst = 1'b0;

      // Directed vectors: valid_out low after one edge, high after two.
      foreach (vecs[i]) begin
         cycle(vecs[i].cw, 1'b1, 1'b0, 1'b1);
         chk("latency_edge1", 32'(valid_out), 32'd0);
         cycle('0, 1'b0, 1'b0, 1'b1);
         chk("vec_valid", 32'(valid_out), 32'd1);
         chk("vec_data", 32'(raw_data), 32'(vecs[i].data));
         chk("vec_syn", 32'(syndrome_out), 32'(vecs[i].syn));
         chk("vec_ec", 32'(err_corrected), 32'(vecs[i].ec));
         chk("vec_eu", 32'(err_uncorrectable), 32'(vecs[i].eu));
         cycle('0, 1'b0, 1'b0, 1'b1);
      end

      // Randomized traffic: clean, single-flip and arbitrary words with gaps.
      for (int n = 0; n < 400; n++) begin
         d = 16'($urandom);
         w = ref_encode(d);
         case ($urandom_range(0, 3))
            0: ;
            1, 2: w[$urandom_range(0, 20)] ^= 1'b1;
            default: w = 21'($urandom);
         endcase
         cycle(w, ($urandom_range(0, 4) != 0), ($urandom_range(0, 40) == 0), 1'b1);
      end
      cycle('0, 1'b0, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1);

      // Drive the corrected counter into saturation.
      cycle(21'h000004, 1'b1, 1'b1, 1'b1);
      for (int n = 0; n < 65540; n++) cycle(21'h000004, 1'b1, 1'b0, 1'b0);
      chk("corr_sat", 32'(corr_count), 32'h0000FFFF);
      for (int n = 0; n < 3; n++) cycle(21'h000004, 1'b1, 1'b0, 1'b1);
      chk("corr_sat_hold", 32'(corr_count), 32'h0000FFFF);

      // Clear coinciding with a correction event: clear wins.
      cycle(21'h000004, 1'b1, 1'b1, 1'b1);
      chk("clr_priority", 32'(corr_count), 32'd0);
      chk("clr_priority_ec", 32'(err_corrected), 32'd1);
      cycle(21'h100002, 1'b1, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1);

      // Reset with two words in flight.
      cycle(21'h000004, 1'b1, 1'b0, 1'b1);
      cycle(21'h100002, 1'b1, 1'b0, 1'b1);
      encoded_data = 21'h000003;
      valid_in     = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk_model();
      chk("rst_raw_zero", 32'(raw_data), 32'd0);
      @(negedge clk);
      #1;
      chk_model();
      @(posedge clk);
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         cycle('0, 1'b0, 1'b0, 1'b1);
         chk("no_valid_after_rst", 32'(valid_out), 32'd0);
      end

      // First word after reset release.
      cycle(21'h1FFFFE, 1'b1, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1);
      chk("post_rst_word", 32'(raw_data), 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
